mux_sel_arbiter: RTL and testbench

MUX_SEL_ARBITER -- requirements
Module: mux_sel_arbiter

---
 rtl/mux_sel_arbiter.sv | 126 ++++++++++++
 tb/tb_mux_sel_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux_sel_arbiter.sv
// Round-robin 16:1 mux-select arbiter with a bounded per-grant hold time.
// Latency: request to valid grant is 1 cycle; all outputs come straight from flops.
// Backpressure: a grantee keeps the path until it drops req or MAX_HOLD cycles pass.
module mux_sel_arbiter #(
    parameter int MAX_HOLD = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] req,
    output logic [15:0] grant,
    output logic [3:0]  sel,
    output logic        valid
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t      state_q, state_d;
    logic [3:0]  ptr_q, ptr_d;
    logic [7:0]  hold_cnt_q, hold_cnt_d;
    logic [3:0]  sel_q, sel_d;
    logic [15:0] grant_q, grant_d;
    logic        valid_q, valid_d;

    logic [3:0]  scan_base;
    logic        win_found;
    logic [3:0]  win_idx;
    logic        release_now;

    // Scan start: the stored pointer when idle, or the pointer a release would
    // install (sel+1) when granting, so release and re-arbitration share a cycle.
    always_comb begin
        scan_base = ptr_q;
        if (state_q == GRANT) begin
            scan_base = sel_q + 4'd1;
        end
    end

    // Pick the first requester at or after scan_base, wrapping modulo 16.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 4'd0;
        for (int k = 0; k < 16; k++) begin
            if (!win_found && req[scan_base + 4'(k)]) begin
                win_found = 1'b1;
                win_idx   = scan_base + 4'(k);
            end
        end
    end

    // The current grantee gives up the path when it stops asking or its hold expires.
    always_comb begin
        release_now = !req[sel_q] || (hold_cnt_q == HOLD_LAST);
    end

    // Next-state and next-output logic for the IDLE/GRANT machine.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        sel_d      = sel_q;
        grant_d    = grant_q;
        valid_d    = valid_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d    = GRANT;
                    sel_d      = win_idx;
                    grant_d    = 16'(1) << win_idx;
                    valid_d    = 1'b1;
                    hold_cnt_d = 8'd0;
                end
            end
            GRANT: begin
                if (!release_now) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end else begin
                    ptr_d = sel_q + 4'd1;
                    if (win_found) begin
                        sel_d      = win_idx;
                        grant_d    = 16'(1) << win_idx;
                        valid_d    = 1'b1;
                        hold_cnt_d = 8'd0;
                    end else begin
                        // sel deliberately keeps the last grantee while idle.
                        state_d    = IDLE;
                        grant_d    = 16'd0;
                        valid_d    = 1'b0;
                        hold_cnt_d = 8'd0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset wins over any request activity.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= 4'd0;
            hold_cnt_q <= 8'd0;
            sel_q      <= 4'd0;
            grant_q    <= 16'd0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            sel_q      <= sel_d;
            grant_q    <= grant_d;
            valid_q    <= valid_d;
        end
    end

    assign grant = grant_q;
    assign sel   = sel_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Self-checking bench for mux_sel_arbiter against a queue-free behavioural model.
// Latency: outputs compared 1ns after every rising edge.
// Backpressure: none; req is driven freely each cycle.
module tb_mux_sel_arbiter;

    localparam int MAX_HOLD = 4;

    logic        clk;
    logic        reset;
    logic [15:0] req;
    logic [15:0] grant;
    logic [3:0]  sel;
    logic        valid;

    int n_vec;
    int n_err;

    // behavioural model state
    bit m_active;
    int m_ptr;
    int m_hold;
    int m_sel;

    mux_sel_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .grant (grant),
        .sel   (sel),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // First requester found scanning p, p+1, ... modulo 16; -1 if none.
    function automatic int model_winner(input logic [15:0] r, input int p);
        for (int k = 0; k < 16; k++) begin
            if (r[(p + k) % 16]) return (p + k) % 16;
        end
        return -1;
    endfunction

    function automatic logic [15:0] exp_grant();
        return m_active ? (16'd1 << m_sel) : 16'd0;
    endfunction

    function automatic logic [3:0] exp_sel();
        return 4'(m_sel);
    endfunction

    function automatic logic exp_valid();
        return m_active;
    endfunction

    task automatic model_step(input logic [15:0] r, input logic rs);
        int w;
        if (rs) begin
            m_active = 0; m_ptr = 0; m_hold = 0; m_sel = 0;
        end else if (!m_active) begin
            w = model_winner(r, m_ptr);
            if (w >= 0) begin
                m_active = 1; m_sel = w; m_hold = 0;
            end
        end else if (r[m_sel] && m_hold != MAX_HOLD - 1) begin
            m_hold = m_hold + 1;
        end else begin
            m_ptr = (m_sel + 1) % 16;
            w = model_winner(r, m_ptr);
            m_hold = 0;
            if (w >= 0) m_sel = w;
            else m_active = 0;
        end
    endtask

    // Drive one cycle of inputs, advance model at the edge, return 1ns after it.
    task automatic tick(input logic [15:0] r, input logic rs);
        req   = r;
        reset = rs;
        @(posedge clk);
        model_step(r, rs);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(16'hFFFF, 1'b1);
            n_vec++;
            if (valid !== 1'b0 || grant !== 16'd0 || sel !== 4'd0) begin
                n_err++;
                $display("FAIL reset_hold cyc%0d: got valid=%b grant=%h sel=%0d, want 0/0000/0", i, valid, grant, sel);
            end
        end
        tick(16'hFFFF, 1'b0);
        n_vec++;
        if (valid !== 1'b1 || grant !== 16'h0001 || sel !== 4'd0) begin
            n_err++;
            $display("FAIL reset_first_grant: got valid=%b grant=%h sel=%0d, want 1/0001/0", valid, grant, sel);
        end
    endtask

    task automatic test_alternate();
        tick(16'h0000, 1'b1);
        for (int i = 0; i < 24; i++) begin
            tick(16'h0081, 1'b0);
            n_vec++;
            if (grant !== exp_grant() || sel !== exp_sel() || valid !== 1'b1 ||
                sel !== ((i / 4) % 2 == 0 ? 4'd0 : 4'd7)) begin
                n_err++;
                $display("FAIL alternate cyc%0d: got grant=%h sel=%0d valid=%b, want grant=%h sel=%0d valid=1",
                         i, grant, sel, valid, exp_grant(), exp_sel());
            end
        end
    endtask

    task automatic test_single();
        tick(16'h0000, 1'b1);
        for (int i = 0; i < 12; i++) begin
            tick(16'h0020, 1'b0);
            n_vec++;
            if (sel !== 4'd5 || valid !== 1'b1 || grant !== 16'h0020 ||
                dut.hold_cnt_q !== 8'(i % MAX_HOLD)) begin
                n_err++;
                $display("FAIL single_req5 cyc%0d: got sel=%0d valid=%b grant=%h hold=%0d, want 5/1/0020/%0d",
                         i, sel, valid, grant, dut.hold_cnt_q, i % MAX_HOLD);
            end
        end
    endtask

    task automatic test_drop();
        tick(16'h0000, 1'b1);
        tick(16'h0018, 1'b0);
        tick(16'h0018, 1'b0);
        tick(16'h0010, 1'b0);
        n_vec++;
        if (sel !== 4'd4 || grant !== 16'h0010 || valid !== 1'b1 || grant !== exp_grant()) begin
            n_err++;
            $display("FAIL drop_to_4: got sel=%0d grant=%h valid=%b, want 4/0010/1", sel, grant, valid);
        end
        tick(16'h0000, 1'b1);
        tick(16'h0008, 1'b0);
        tick(16'h0008, 1'b0);
        n_vec++;
        if (sel !== 4'd3 || valid !== 1'b1) begin
            n_err++;
            $display("FAIL drop_hold3: got sel=%0d valid=%b, want 3/1", sel, valid);
        end
        tick(16'h0000, 1'b0);
        n_vec++;
        if (sel !== 4'd3 || grant !== 16'd0 || valid !== 1'b0 || valid !== exp_valid()) begin
            n_err++;
            $display("FAIL drop_to_idle: got sel=%0d grant=%h valid=%b, want 3/0000/0", sel, grant, valid);
        end
    endtask

    task automatic test_wrap();
        tick(16'h0000, 1'b1);
        tick(16'h8000, 1'b0);
        for (int i = 0; i < MAX_HOLD; i++) begin
            tick(16'h8001, 1'b0);
            n_vec++;
            if (valid !== 1'b1 || sel !== exp_sel() || grant !== exp_grant() ||
                sel !== (i == MAX_HOLD - 1 ? 4'd0 : 4'd15)) begin
                n_err++;
                $display("FAIL wrap cyc%0d: got sel=%0d grant=%h valid=%b, want sel=%0d grant=%h valid=1",
                         i, sel, grant, valid, exp_sel(), exp_grant());
            end
        end
    endtask

    task automatic test_reset_mid();
        tick(16'h0000, 1'b1);
        tick(16'h0200, 1'b0);
        tick(16'h0201, 1'b0);
        n_vec++;
        if (sel !== 4'd9 || valid !== 1'b1) begin
            n_err++;
            $display("FAIL mid_pre: got sel=%0d valid=%b, want 9/1", sel, valid);
        end
        tick(16'h0201, 1'b1);
        n_vec++;
        if (valid !== 1'b0 || grant !== 16'd0 || sel !== 4'd0) begin
            n_err++;
            $display("FAIL mid_reset: got valid=%b grant=%h sel=%0d, want 0/0000/0", valid, grant, sel);
        end
        tick(16'h0201, 1'b0);
        n_vec++;
        if (sel !== 4'd0 || grant !== 16'h0001 || valid !== 1'b1) begin
            n_err++;
            $display("FAIL mid_after: got sel=%0d grant=%h valid=%b, want 0/0001/1", sel, grant, valid);
        end
    endtask

    task automatic test_random();
        logic [15:0] r;
        logic        rs;
        r = 16'h0000;
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 4))
                0: r = 16'h0000;
                1: r = 16'd1 << $urandom_range(0, 15);
                2: r = 16'($urandom);
                3: r = r ^ (16'd1 << $urandom_range(0, 15));
                default: r = r;
            endcase
            rs = ($urandom_range(0, 49) == 0);
            tick(r, rs);
            n_vec++;
            if (grant !== exp_grant() || sel !== exp_sel() || valid !== exp_valid()) begin
                n_err++;
                $display("FAIL random cyc%0d req=%h rst=%b: got grant=%h sel=%0d valid=%b, want grant=%h sel=%0d valid=%b",
                         i, r, rs, grant, sel, valid, exp_grant(), exp_sel(), exp_valid());
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        m_active = 0; m_ptr = 0; m_hold = 0; m_sel = 0;
        req   = 16'h0000;
        reset = 1'b1;
        test_reset();
        test_alternate();
        test_single();
        test_drop();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
